weight_update_module: RTL and testbench
=======================================

// Module: weight_update_module
// PURPOSE
//   Weight-bank update stage directly downstream of the delta-weight-2 generator.
//   - Holds the layer-2 weight bank in registers.
//   - Consumes one scaled delta-weight per handshake and applies w[i] <= sat(w[i] - deltaw).
//   - Serves combinational weight reads to the forward-pass datapath.
//   - Format: signed Q6.10 throughout (1.0 = 16'h0400).
// PARAMETERS
//   N_WEIGHTS  8        number of weights in the bank (>= 2)
//   DATA_W     16       word width, signed Q6.10
//   ADDR_W     3        index width; must equal clog2(N_WEIGHTS)
//   INIT_W     16'h0100 reset value loaded into every weight (0.25)
//   UPD_CTRL   4'd10    controller phase that starts an update pass
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous reset, active-low (rst==0 resets)
//   step         in   4       training step; 0 = warm-up, updates inhibited
//   controller   in   4       global sequencer phase
//   deltaw_valid in   1       deltaw_in is valid this cycle
//   deltaw_in    in   DATA_W  scaled delta-weight for the current index
//   deltaw_ready out  1       block accepts deltaw_in this cycle
//   rd_addr      in   ADDR_W  forward-pass read index
//   rd_data      out  DATA_W  w[rd_addr], combinational
//   busy         out  1       update pass in progress
//   upd_done     out  1       one-cycle pulse when a pass completes
//   sat_flag     out  1       sticky: set if any update saturated in current pass
// BEHAVIOUR
//   - Reset (rst==0 at clk edge):
//     - all w[i] = INIT_W; state = IDLE; idx = 0;
//     - busy = 0, upd_done = 0, sat_flag = 0, deltaw_ready = 0.
//     - Reset applied mid-pass abandons the pass; the weights written so far are also re-initialised.
//   - FSM states: IDLE, UPDATE, DONE.
//     - IDLE -> UPDATE: when step != 0 and controller == UPD_CTRL. Same edge: idx = 0, sat_flag = 0.
//     - IDLE: stays IDLE while step == 0, whatever the controller value.
//     - UPDATE: deltaw_ready = 1 (registered state decode, no dependence on deltaw_valid).
//       - Handshake = deltaw_valid & deltaw_ready, one word per cycle.
//       - On handshake: w[idx] <= sat(w[idx] - deltaw_in), then idx <= idx + 1.
//       - No handshake: nothing changes; stalls are unbounded.
//       - Handshake at idx == N_WEIGHTS-1: idx wraps to 0 and state -> DONE.
//     - DONE: upd_done = 1 for exactly this cycle; deltaw_ready = 0; next state IDLE.
//     - A new pass requires controller to leave UPD_CTRL, then return to it. Track the previous controller value and start only on the edge into UPD_CTRL.
//   - busy = (state != IDLE).
//   - Arithmetic:
//     - 17-bit signed difference of w[idx] and deltaw_in.
//     - Result > 16'h7FFF -> 16'h7FFF; result < 16'h8000 -> 16'h8000.
//     - On either clamp, sat_flag <= 1. It holds until the next pass starts or reset.
//   - Read port:
//     - rd_data reflects the registered bank, so a write at edge k is visible after edge k.
//     - Same-cycle read of the index being written returns the old value.
//     - rd_addr >= N_WEIGHTS returns 0.
//   - Latency: one cycle from handshake to updated weight. A full pass with no stalls is N_WEIGHTS+1 cycles from the start edge to upd_done.
//   - deltaw_valid outside UPDATE is ignored; no state change.
// STRUCTURE
//   - Shared package (nn_fixed_pkg):
//     - DATA_W and FRAC_W = 10;
//     - Q6.10 constants ONE = 16'h0400, QMAX = 16'h7FFF, QMIN = 16'h8000;
//     - controller phase encodings, including UPD_CTRL = 4'd10;
//     - the state typedef {IDLE, UPDATE, DONE}.
//   - Sub-module: sat_sub16. Combinational saturating subtract a-b, with outputs result and sat. Reused by the layer-1 update.
//   - Remaining logic: FSM, index counter, register bank and read mux, all in this module.
// TESTING
//   1. Reset: rst=0 for 2 cycles -> every rd_data = 16'h0100; busy = 0; upd_done = 0; sat_flag = 0.
//   2. Warm-up inhibit: step=0, controller=10, deltaw_valid=1 for 10 cycles -> busy stays 0 and the weights are unchanged.
//   3. Full pass: step=1, controller 9->10. Drive 8 handshakes, deltaw_in = 16'h0020 each.
//      -> every w = 16'h00E0.
//      -> upd_done pulses 9 cycles after the start edge.
//      -> sat_flag = 0.
//   4. Stall: deltaw_valid toggled 1,0,0,1,... -> each index is updated exactly once; idx holds during stalls; upd_done follows the 8th handshake by one cycle.
//   5. Saturation: w[0] preset near max via repeated deltaw_in = 16'h8000 (-32.0) across passes.
//      -> w[0] clamps at 16'h7FFF; sat_flag = 1.
//      -> sat_flag clears at the next pass start.
//   6. Reset mid-pass: rst=0 after 3 handshakes -> all w = 16'h0100; state IDLE; idx restarts at 0 on the next pass.

Source files
------------

// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the training datapath.
// Everything here is signed Q6.10: 6 integer bits, 10 fraction bits.
package nn_fixed_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;

  localparam logic [DATA_W-1:0] ONE  = 16'h0400;
  localparam logic [DATA_W-1:0] QMAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] QMIN = 16'h8000;

  // Global sequencer phase encodings
  localparam logic [3:0] CTRL_IDLE    = 4'd0;
  localparam logic [3:0] CTRL_FORWARD = 4'd1;
  localparam logic [3:0] CTRL_ERROR   = 4'd2;
  localparam logic [3:0] CTRL_DELTA1  = 4'd8;
  localparam logic [3:0] CTRL_DELTA2  = 4'd9;
  localparam logic [3:0] UPD_CTRL     = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } upd_state_e;

endpackage

// File: rtl/sat_sub16.sv
// Combinational saturating subtract (a - b) for signed Q6.10 words.
// Shared by the layer-1 and layer-2 weight update stages.
module sat_sub16
  import nn_fixed_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              sat
);

  logic [DATA_W:0] diff;

  // One extra bit of headroom; the top two bits disagree exactly when the
  // true difference falls outside the 16-bit signed range.
  always_comb begin
    diff   = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    sat    = diff[DATA_W] ^ diff[DATA_W-1];
    result = diff[DATA_W-1:0];
    if (sat) begin
      result = diff[DATA_W] ? QMIN : QMAX;
    end
  end

endmodule

// File: rtl/weight_update_module.sv
// Layer-2 weight bank with a saturating per-word update pass and a
// combinational read port for the forward pass.
module weight_update_module #(
  parameter int                N_WEIGHTS = 8,
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 3,
  parameter logic [DATA_W-1:0] INIT_W    = 16'h0100,
  parameter logic [3:0]        UPD_CTRL  = nn_fixed_pkg::UPD_CTRL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        step,
  input  logic [3:0]        controller,
  input  logic              deltaw_valid,
  input  logic [DATA_W-1:0] deltaw_in,
  output logic              deltaw_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              upd_done,
  output logic              sat_flag
);

  import nn_fixed_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WEIGHTS - 1);

  upd_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              satFlag_q, satFlag_d;
  logic [3:0]        ctrlPrev_q;
  logic [DATA_W-1:0] w_q [N_WEIGHTS];

  logic              handshake;
  logic              startPass;
  logic [DATA_W-1:0] curW;
  logic [DATA_W-1:0] subResult;
  logic              subSat;

  assign deltaw_ready = (state_q == UPDATE);
  assign busy         = (state_q != IDLE);
  assign upd_done     = (state_q == DONE);
  assign sat_flag     = satFlag_q;
  assign handshake    = deltaw_valid & deltaw_ready;
  assign curW         = w_q[idx_q];

  // A pass starts only on the cycle the controller moves into the update
  // phase, and never during warm-up (step 0).
  assign startPass = (step != 4'd0) && (controller == UPD_CTRL) &&
                     (ctrlPrev_q != UPD_CTRL);

  sat_sub16 u_sat_sub (
    .a      (curW),
    .b      (deltaw_in),
    .result (subResult),
    .sat    (subSat)
  );

  // Next-state logic: pass sequencing, index advance and sticky saturation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    satFlag_d = satFlag_q;
    unique case (state_q)
      IDLE: begin
        if (startPass) begin
          state_d   = UPDATE;
          idx_d     = '0;
          satFlag_d = 1'b0;
        end
      end
      UPDATE: begin
        if (handshake) begin
          if (subSat) begin
            satFlag_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; the previous controller value feeds edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      satFlag_q  <= 1'b0;
      ctrlPrev_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      satFlag_q  <= satFlag_d;
      ctrlPrev_q <= controller;
    end
  end

  // Weight bank: reset re-initialises every word, a handshake writes one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_WEIGHTS; i++) begin
        w_q[i] <= INIT_W;
      end
    end else if (handshake) begin
      w_q[idx_q] <= subResult;
    end
  end

  // Read mux on the registered bank; out-of-range addresses read as zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < N_WEIGHTS) begin
      rd_data = w_q[rd_addr];
    end
  end

endmodule

// File: tb/tb_weight_update_module.sv
// Randomised scoreboard bench for weight_update_module.
`timescale 1ns/100ps
module tb_weight_update_module;

  localparam int NW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  step;
  logic [3:0]  controller;
  logic        deltaw_valid;
  logic [15:0] deltaw_in;
  logic        deltaw_ready;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        upd_done;
  logic        sat_flag;

  typedef struct {
    logic sat;
    int   cycles;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] modelW [NW];
  logic [15:0] passDelta [NW];
  int          total = 0;
  int          bad = 0;
  int          cycleCnt = 0;

  weight_update_module dut (
    .clk          (clk),
    .rst          (rst),
    .step         (step),
    .controller   (controller),
    .deltaw_valid (deltaw_valid),
    .deltaw_in    (deltaw_in),
    .deltaw_ready (deltaw_ready),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .upd_done     (upd_done),
    .sat_flag     (sat_flag)
  );

  // Free-running clock
  always #10 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] st, input logic [3:0] ctl,
                               input logic v, input logic [15:0] d);
    rst          = r;
    step         = st;
    controller   = ctl;
    deltaw_valid = v;
    deltaw_in    = d;
    @(posedge clk);
    #1;
  endtask

  // Saturating Q6.10 subtract computed with plain integer arithmetic
  function automatic logic [15:0] refSub(input logic [15:0] w, input logic [15:0] d,
                                         output logic s);
    int r;
    r = int'($signed(w)) - int'($signed(d));
    s = 1'b0;
    if (r > 32767) begin
      s = 1'b1;
      return 16'h7FFF;
    end
    if (r < -32768) begin
      s = 1'b1;
      return 16'h8000;
    end
    return r[15:0];
  endfunction

  task automatic resetModel();
    for (int i = 0; i < NW; i++) modelW[i] = 16'h0100;
  endtask

  task automatic checkBank(input string name);
    for (int i = 0; i < NW; i++) begin
      rd_addr = 3'(i);
      #1;
      checkOutput($sformatf("%s_w%0d", name, i), 32'(rd_data), 32'(modelW[i]));
    end
  endtask

  // One update pass: maxStall idle cycles at most before each word; abortAt < NW
  // applies reset after that many handshakes instead of finishing the pass.
  task automatic runPass(input string name, input int maxStall, input int abortAt);
    logic [15:0] nextW [NW];
    int          stalls [NW];
    int          stallSum;
    logic        passSat;
    logic        s;
    int          budget;
    stallSum = 0;
    passSat  = 1'b0;
    for (int i = 0; i < NW; i++) begin
      nextW[i]  = refSub(modelW[i], passDelta[i], s);
      passSat   = passSat | s;
      stalls[i] = $urandom_range(0, maxStall);
      stallSum += stalls[i];
    end
    if (abortAt >= NW) expQ.push_back('{sat: passSat, cycles: stallSum + NW + 1});

    applyStimulus(1'b1, 4'd1, 4'd9, 1'b0, 16'h0);
    applyStimulus(1'b1, 4'd1, 4'd10, 1'b0, 16'h0);
    checkOutput({name, "_busy_start"}, 32'(busy), 32'd1);
    checkOutput({name, "_sat_clear"}, 32'(sat_flag), 32'd0);

    for (int i = 0; i < NW; i++) begin
      if (i == abortAt) begin
        applyStimulus(1'b0, 4'd1, 4'd9, 1'b1, 16'h1234);
        applyStimulus(1'b0, 4'd1, 4'd9, 1'b0, 16'h0);
        resetModel();
        return;
      end
      for (int k = 0; k < stalls[i]; k++) begin
        applyStimulus(1'b1, 4'd1, 4'd10, 1'b0, 16'($urandom));
      end
      budget = 0;
      while (!deltaw_ready && budget < 20) begin
        applyStimulus(1'b1, 4'd1, 4'd10, 1'b0, 16'h0);
        budget++;
      end
      if (!deltaw_ready) begin
        checkOutput({name, "_ready_timeout"}, 32'(deltaw_ready), 32'd1);
        return;
      end
      applyStimulus(1'b1, 4'd1, 4'd10, 1'b1, passDelta[i]);
    end
    for (int i = 0; i < NW; i++) modelW[i] = nextW[i];

    budget = 0;
    while (busy && budget < 10) begin
      applyStimulus(1'b1, 4'd1, 4'd10, 1'b0, 16'h0);
      budget++;
    end
    checkOutput({name, "_idle_after"}, 32'(busy), 32'd0);
    checkBank(name);
  endtask

  // Monitor: on every upd_done pop the expected pass outcome and compare
  // the sticky saturation flag and the pass length.
  always @(negedge clk) begin
    if (busy) cycleCnt++;
    if (upd_done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_upd_done", 32'(upd_done), 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("done_sat_flag", 32'(sat_flag), 32'(e.sat));
        checkOutput("done_cycles", 32'(cycleCnt), 32'(e.cycles));
      end
    end
    if (!busy) cycleCnt = 0;
  end

  initial begin
    rd_addr = 3'd0;
    $display("[TB] start");

    // Reset state
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 16'h0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 16'h0);
    resetModel();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(upd_done), 32'd0);
    checkOutput("rst_sat", 32'(sat_flag), 32'd0);
    checkOutput("rst_ready", 32'(deltaw_ready), 32'd0);
    checkBank("rst");

    // Warm-up: step 0 inhibits updates whatever the controller does
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'd0, 4'd10, 1'b1, 16'($urandom));
      checkOutput("warm_busy", 32'(busy), 32'd0);
    end
    checkBank("warm");

    // Full pass without stalls, constant delta
    for (int i = 0; i < NW; i++) passDelta[i] = 16'h0020;
    runPass("full", 0, NW);

    // Holding the controller in the update phase must not restart a pass
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'd1, 4'd10, 1'b1, 16'h0010);
      checkOutput("hold_no_restart", 32'(busy), 32'd0);
    end

    // Stalled pass with random small deltas
    for (int i = 0; i < NW; i++) passDelta[i] = 16'($urandom_range(0, 16'h0200)) - 16'h0100;
    runPass("stall", 3, NW);

    // Saturation: -32.0 deltas drive every non-negative weight to QMAX
    for (int i = 0; i < NW; i++) passDelta[i] = 16'h8000;
    runPass("satur", 1, NW);
    checkOutput("sat_sticky", 32'(sat_flag), 32'd1);
    checkOutput("sat_w0", 32'(modelW[0]), 32'h7FFF);

    // Random passes across the full range, including negative clamps
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < NW; i++) passDelta[i] = 16'($urandom);
      runPass("rand", 2, NW);
    end

    // Reset after three handshakes abandons the pass and re-inits the bank
    for (int i = 0; i < NW; i++) passDelta[i] = 16'($urandom);
    runPass("abort", 1, 3);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_sat", 32'(sat_flag), 32'd0);
    checkBank("abort");

    // Next pass must start again from index 0
    for (int i = 0; i < NW; i++) passDelta[i] = 16'(i * 16'h0011);
    runPass("after_abort", 2, NW);

    applyStimulus(1'b1, 4'd1, 4'd9, 1'b0, 16'h0);
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
